// File: rtl/decode_stage.sv
// decode_stage: combinational instruction decode feeding a DEPTH-entry FIFO.
// The decoded bundle is captured into the queue on accept; every o_* field is
// driven straight from the registered head entry.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   i_inst            32-bit instruction word
//   i_inst_valid      i_inst present
//   o_inst_ready      queue can accept (count < DEPTH), registered
//   i_flush           drop all queued and incoming instructions
//   o_valid           head entry present
//   i_ready           consumer takes the head when o_valid is high
//   o_type            0 = R-type, 1 = I/J-type (op[5])
//   o_op              opcode i_inst[31:26]
//   o_dst/o_src0/o_src1  register fields, MSB-first from i_inst[25:0]
//   o_imm             extended immediate
//   o_wb ... o_illegal   instruction class flags
module decode_stage #(
  parameter int unsigned WORD_BITS = 32,
  parameter int unsigned REG_BITS  = 5,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          i_inst,
  input  logic                 i_inst_valid,
  output logic                 o_inst_ready,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_type,
  output logic [5:0]           o_op,
  output logic [REG_BITS-1:0]  o_dst,
  output logic [REG_BITS-1:0]  o_src0,
  output logic [REG_BITS-1:0]  o_src1,
  output logic [WORD_BITS-1:0] o_imm,
  output logic                 o_wb,
  output logic                 o_read_req,
  output logic                 o_write_req,
  output logic                 o_jr,
  output logic                 o_j,
  output logic                 o_jal,
  output logic                 o_branch,
  output logic                 o_illegal
);

  localparam int unsigned IMM_BITS = 26 - 2 * REG_BITS;
  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                 typ;
    logic [5:0]           op;
    logic [REG_BITS-1:0]  dst;
    logic [REG_BITS-1:0]  src0;
    logic [REG_BITS-1:0]  src1;
    logic [WORD_BITS-1:0] imm;
    logic                 wb;
    logic                 rd;
    logic                 wr;
    logic                 jr;
    logic                 j;
    logic                 jal;
    logic                 br;
    logic                 ill;
  } dec_t;

  dec_t                dec_c;
  dec_t                head_c;
  dec_t                mem_q [DEPTH];
  logic [IMM_BITS-1:0] imm_raw_c;
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                ready_q, ready_d;
  logic                push_c, pop_c;

  assign imm_raw_c = i_inst[IMM_BITS-1:0];

  // Instruction decode; unknown opcodes keep their fields but raise only o_illegal.
  always_comb begin
    dec_c      = '0;
    dec_c.typ  = i_inst[31];
    dec_c.op   = i_inst[31:26];
    dec_c.dst  = i_inst[25 -: REG_BITS];
    dec_c.src0 = i_inst[25-REG_BITS -: REG_BITS];
    dec_c.src1 = i_inst[25-2*REG_BITS -: REG_BITS];
    case (i_inst[31:26])
      6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A, 6'h0C, 6'h0E,
      6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16: dec_c.wb = 1'b1;
      6'h17: dec_c.jr = 1'b1;
      6'h20, 6'h22, 6'h24, 6'h26, 6'h2E: begin
        dec_c.wb  = 1'b1;
        dec_c.imm = WORD_BITS'($signed(imm_raw_c));
      end
      6'h28: begin
        dec_c.wb  = 1'b1;
        dec_c.rd  = 1'b1;
        dec_c.imm = WORD_BITS'($signed(imm_raw_c));
      end
      6'h29: begin
        dec_c.wr  = 1'b1;
        dec_c.imm = WORD_BITS'($signed(imm_raw_c));
      end
      6'h2A, 6'h2B, 6'h2F: begin
        dec_c.wb  = 1'b1;
        dec_c.imm = WORD_BITS'(imm_raw_c);
      end
      6'h2C, 6'h2D: begin
        dec_c.br  = 1'b1;
        dec_c.imm = WORD_BITS'($signed(imm_raw_c));
      end
      6'h30: begin
        dec_c.j   = 1'b1;
        dec_c.imm = WORD_BITS'(i_inst[25:0]);
      end
      6'h31: begin
        dec_c.jal = 1'b1;
        dec_c.wb  = 1'b1;
        dec_c.imm = WORD_BITS'(i_inst[25:0]);
      end
      default: dec_c.ill = 1'b1;
    endcase
  end

  // Ready is taken from registered state only, so i_ready never reaches o_inst_ready.
  assign push_c = i_inst_valid & ready_q;
  assign pop_c  = (count_q != '0) & i_ready;

  // Queue pointer / occupancy next state; flush overrides any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_BITS'(1);
        2'b01:   count_d = count_q - CNT_BITS'(1);
        default: count_d = count_q;
      endcase
    end
    ready_d = (count_d < CNT_BITS'(DEPTH));
  end

  // Control state; ready stays low through reset and rises on the first edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Entry storage; cleared on reset so the idle head reads as all zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_c && !i_flush) begin
      mem_q[wr_ptr_q] <= dec_c;
    end
  end

  assign head_c       = mem_q[rd_ptr_q];
  assign o_valid      = (count_q != '0);
  assign o_inst_ready = ready_q;
  assign o_type       = head_c.typ;
  assign o_op         = head_c.op;
  assign o_dst        = head_c.dst;
  assign o_src0       = head_c.src0;
  assign o_src1       = head_c.src1;
  assign o_imm        = head_c.imm;
  assign o_wb         = head_c.wb;
  assign o_read_req   = head_c.rd;
  assign o_write_req  = head_c.wr;
  assign o_jr         = head_c.jr;
  assign o_j          = head_c.j;
  assign o_jal        = head_c.jal;
  assign o_branch     = head_c.br;
  assign o_illegal    = head_c.ill;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// queue-based reference model that decodes from the opcode tables directly.
module tb_decode_stage;

  localparam int unsigned WB    = 32;
  localparam int unsigned RB    = 5;
  localparam int unsigned IB    = 26 - 2 * RB;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   i_inst;
  logic          i_inst_valid;
  logic          o_inst_ready;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic          o_type;
  logic [5:0]    o_op;
  logic [RB-1:0] o_dst, o_src0, o_src1;
  logic [WB-1:0] o_imm;
  logic          o_wb, o_read_req, o_write_req, o_jr, o_j, o_jal, o_branch, o_illegal;

  decode_stage #(.WORD_BITS(WB), .REG_BITS(RB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_inst(i_inst), .i_inst_valid(i_inst_valid),
    .o_inst_ready(o_inst_ready), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_type(o_type), .o_op(o_op), .o_dst(o_dst),
    .o_src0(o_src0), .o_src1(o_src1), .o_imm(o_imm), .o_wb(o_wb),
    .o_read_req(o_read_req), .o_write_req(o_write_req), .o_jr(o_jr),
    .o_j(o_j), .o_jal(o_jal), .o_branch(o_branch), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  // Bundle layout: {type, op, dst, src0, src1, imm[31:0], wb, rd, wr, jr, j, jal, br, ill}
  logic [61:0] obs;
  assign obs = {o_type, o_op, o_dst, o_src0, o_src1, o_imm,
                o_wb, o_read_req, o_write_req, o_jr, o_j, o_jal, o_branch, o_illegal};

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [61:0] mq[$];
  bit          m_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference decode straight from the opcode tables.
  function automatic logic [61:0] ref_dec(input logic [31:0] inst);
    logic [5:0]  op;
    logic        lr, li, ill, wb;
    longint      raw;
    logic [31:0] imm;
    op  = inst[31:26];
    lr  = (op < 6'h10 && !op[0]) || (op >= 6'h10 && op <= 6'h17);
    li  = op inside {6'h20, 6'h22, 6'h24, 6'h26, [6'h28:6'h31]};
    ill = !(lr || li);
    wb  = !ill && ((lr && op != 6'h17) ||
                   (op inside {6'h20, 6'h22, 6'h24, 6'h26, 6'h28, 6'h2A, 6'h2B,
                               6'h2E, 6'h2F, 6'h31}));
    raw = longint'(inst % (32'd1 << IB));
    imm = 32'd0;
    if (op inside {6'h20, 6'h22, 6'h24, 6'h26, 6'h28, 6'h29, 6'h2C, 6'h2D, 6'h2E}) begin
      if (raw >= (longint'(1) << (IB - 1))) raw = raw - (longint'(1) << IB);
      imm = 32'(raw);
    end else if (op inside {6'h2A, 6'h2B, 6'h2F}) begin
      imm = 32'(raw);
    end else if (op inside {6'h30, 6'h31}) begin
      imm = inst % (32'd1 << 26);
    end
    return {op >= 6'h20, op,
            5'((inst >> 21) % 32), 5'((inst >> 16) % 32), 5'((inst >> 11) % 32), imm,
            wb, op == 6'h28, op == 6'h29, op == 6'h17, op == 6'h30, op == 6'h31,
            (op == 6'h2C || op == 6'h2D), ill};
  endfunction

  // One clock: drive at negedge, advance the model at posedge, compare just after.
  task automatic step(input bit v, input logic [31:0] inst, input bit rdy, input bit fl);
    bit          push, pop;
    logic [61:0] e, o;
    @(negedge clk);
    i_inst_valid = v; i_inst = inst; i_ready = rdy; i_flush = fl;
    @(posedge clk);
    push = v && m_ready;
    pop  = (mq.size() > 0) && rdy;
    if (fl) mq.delete();
    else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(ref_dec(inst));
    end
    m_ready = (mq.size() < DEPTH);
    #1;
    chk("valid", 64'(o_valid), 64'(mq.size() > 0));
    chk("inst_ready", 64'(o_inst_ready), 64'(m_ready));
    if (mq.size() > 0) begin
      e = mq[0];
      o = obs;
      if (e[0]) o[39:8] = e[39:8];  // immediate of an illegal op is unspecified
      chk("head", 64'(o), 64'(e));
    end
  endtask

  logic [5:0] legal_ops [30] = '{6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A, 6'h0C, 6'h0E,
                                  6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17,
                                  6'h20, 6'h22, 6'h24, 6'h26, 6'h28, 6'h29, 6'h2A, 6'h2B,
                                  6'h2C, 6'h2D, 6'h2E, 6'h2F, 6'h30, 6'h31};

  initial begin
    logic [5:0]  op;
    logic [31:0] inst;
    rst = 1'b1; i_inst = '0; i_inst_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_inst_ready), 64'd0);
    @(negedge clk); rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_fields", 64'(obs), 64'd0);

    // Directed decodes, each pushed with i_ready=1 so it becomes the head next.
    step(1'b1, 32'h00221800, 1'b1, 1'b0);
    chk("r_add", 64'(obs), 64'({1'b0, 6'h00, 5'd1, 5'd2, 5'd3, 32'h0, 8'b1000_0000}));
    step(1'b1, 32'hA0228003, 1'b1, 1'b0);
    chk("lw", 64'(obs), 64'({1'b1, 6'h28, 5'd1, 5'd2, 5'd16, 32'hFFFF8003, 8'b1100_0000}));
    step(1'b1, 32'hA4220003, 1'b1, 1'b0);
    chk("sw", 64'(obs), 64'({1'b1, 6'h29, 5'd1, 5'd2, 5'd0, 32'h3, 8'b0010_0000}));
    step(1'b1, 32'hC4000004, 1'b1, 1'b0);
    chk("jal", 64'(obs), 64'({1'b1, 6'h31, 5'd0, 5'd0, 5'd0, 32'h4, 8'b1000_0100}));
    step(1'b1, 32'h5C010000, 1'b1, 1'b0);
    chk("jr", 64'(obs), 64'({1'b0, 6'h17, 5'd0, 5'd1, 5'd0, 32'h0, 8'b0001_0000}));
    step(1'b1, 32'hFC000000, 1'b1, 1'b0);
    chk("illegal", 64'({o_op, o_wb, o_read_req, o_write_req, o_jr, o_j, o_jal, o_branch, o_illegal}),
        64'({6'h3F, 8'b0000_0001}));
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Fill with consumer stalled, try extra pushes, then drain in order.
    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, {6'h20, 26'(i + 1)}, 1'b0, 1'b0);
    chk("full_ready", 64'(o_inst_ready), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 64'(o_imm), 64'(i + 1));
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("drain_ready", 64'(o_inst_ready), 64'd1);
    end

    // Flush with two entries queued and a simultaneous push.
    step(1'b1, 32'h00221800, 1'b0, 1'b0);
    step(1'b1, 32'h04221800, 1'b0, 1'b0);
    step(1'b1, 32'h08221800, 1'b1, 1'b1);
    chk("flush_valid", 64'(o_valid), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_gone", 64'(o_valid), 64'd0);

    // Reset asserted between edges with entries queued.
    step(1'b1, 32'hA0228003, 1'b0, 1'b0);
    step(1'b1, 32'hA4220003, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_ready", 64'(o_inst_ready), 64'd0);
    mq.delete();
    m_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("midrst_fields", 64'(obs), 64'd0);
    step(1'b1, 32'h00221800, 1'b0, 1'b0);
    chk("post_rst_add", 64'(obs), 64'({1'b0, 6'h00, 5'd1, 5'd2, 5'd3, 32'h0, 8'b1000_0000}));
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 29)];
      inst = {op, 26'($urandom)};
      step(1'($urandom), inst, ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter WORD_BITS, default 32: width of o_imm; 26..64.
REQ-002 Parameter REG_BITS, default 5: register index width; 3..6; IMM_BITS = 26-2*REG_BITS.
REQ-003 Parameter DEPTH, default 2: output queue entries; power of two, >=2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 i_inst  in  32  instruction word.
REQ-007 i_inst_valid  in  1  i_inst present.
REQ-008 o_inst_ready  out  1  queue can accept; i_inst taken when i_inst_valid & o_inst_ready.
REQ-009 i_flush  in  1  discard all queued and incoming instructions.
REQ-010 o_valid  out  1  head entry present.
REQ-011 i_ready  in  1  consumer takes head when o_valid & i_ready.
REQ-012 o_type  out  1  0 = R-type, 1 = I/J-type (op[5]).
REQ-013 o_op  out  6  opcode i_inst[31:26].
REQ-014 o_dst, o_src0, o_src1  out  REG_BITS each  fields taken MSB-first from i_inst[25:0].
REQ-015 o_imm  out  WORD_BITS  extended immediate.
REQ-016 o_wb, o_read_req, o_write_req, o_jr, o_j, o_jal, o_branch, o_illegal  out  1 each  class flags.

Function
REQ-017 Decode: op=[31:26]; dst=[25 -: REG_BITS]; src0 next REG_BITS below; src1 next REG_BITS below; raw imm=[IMM_BITS-1:0].
REQ-018 Legal R ops: 00,02,04,06 (iAdd,iSub,iMul,iDiv), 08,0A,0C,0E (fAdd,fSub,fMul,fDiv), 10..16 (and,or,xor,ucmp,Lsft,Rsft,cmp), 17 (jr); hex.
REQ-019 Legal I ops: 20,22,24,26 (iAddi..iDivi), 28 lw, 29 sw, 2A Lsfti, 2B Rsfti, 2C be, 2D bne, 2E cmpi, 2F ucmpi, 30 j, 31 jal.
REQ-020 Any other op: o_illegal=1, all other flags 0, fields still decoded, entry still queued.
REQ-021 o_imm: sign-extended raw imm for 20..29,2C,2D,2E; zero-extended for 2A,2B,2F; zero-extended i_inst[25:0] for 30,31; 0 for R-type.
REQ-022 o_wb=1 for all legal R except 17, and for 20..28,2A,2B,2E,2F,31; else 0.
REQ-023 o_read_req=1 only op 28; o_write_req=1 only op 29; o_jr only 17; o_j only 30; o_jal only 31; o_branch only 2C,2D.
REQ-024 Decode is combinational on i_inst; decoded bundle is written into queue on accept; outputs driven registered from queue head.
REQ-025 Latency: instruction accepted at edge N is visible with o_valid=1 after edge N when queue was empty.
REQ-026 Queue FIFO order; count 0..DEPTH; push and pop in same cycle keep count unchanged.
REQ-027 o_inst_ready = (count < DEPTH); no combinational path from i_ready to o_inst_ready.
REQ-028 Full: o_inst_ready=0, i_inst ignored even if pop occurs that cycle.
REQ-029 Empty: o_valid=0, i_ready ignored; o_* fields hold last head values, do not care.
REQ-030 Pointers wrap modulo DEPTH.
REQ-031 i_flush=1 at an edge: count becomes 0, same-cycle push and pop discarded; o_valid=0 next cycle.
REQ-032 i_inst_valid low: no push; i_inst may change freely.

Reset
REQ-033 rst=1 asynchronously clears count and pointers; o_valid=0, o_inst_ready=0 while rst=1.
REQ-034 After rst release, o_inst_ready=1 from next cycle; all flag outputs 0 and fields 0 while o_valid=0 after reset.
REQ-035 rst asserted mid-transfer: all queued entries lost, no partial entry survives.

Verification
REQ-036 Push 0x00221800, i_ready=1 -> next cycle o_valid=1, o_type=0, o_op=00, dst=1, src0=2, src1=3, o_wb=1, o_imm=0.
REQ-037 Push 0xA0228003 then 0xA4220003 -> lw: o_read_req=1, o_imm=0xFFFF8003; sw: o_write_req=1, o_wb=0, o_imm=3.
REQ-038 Push 0xC4000004 -> o_jal=1, o_wb=1, o_imm=4; push 0x5C010000 -> o_jr=1, o_wb=0, src0=1; push 0xFC000000 -> o_illegal=1.
REQ-039 i_ready=0, push DEPTH instructions -> o_inst_ready=0; further pushes dropped; then i_ready=1 -> entries drain in order, o_inst_ready=1 one cycle after first pop.
REQ-040 Queue holding 2 entries, assert i_flush with simultaneous push -> next cycle o_valid=0, count 0, pushed instruction never appears.
REQ-041 Assert rst mid-stream between clock edges -> o_valid and o_inst_ready fall immediately; after release first push decodes correctly.
